// File: rtl/vga_raster_gen_pkg.sv
// Display timing package shared by the raster generator and the draw blocks.
// It holds the default 800x600 timing, the derived totals, the counter
// widths and the encoding of the horizontal phase FSM.
package vga_raster_gen_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 23;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;

  // Phase of the next pixel to emit within its line.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } h_phase_e;

  // Internal raster state made visible for checkers.
  typedef struct packed {
    h_phase_e            phase;
    logic [HCNT_W-1:0]   hcnt;
    logic [VCNT_W-1:0]   vcnt;
  } raster_dbg_t;

  // Drive level of a sync line given whether it is asserted.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_raster_gen_if.sv
// Raster bus between the timing generator and the draw blocks.
// pix_ce is a plain qualifier, not a handshake: the generator advances one
// pixel on every clk where pix_ce=1 and there is no back-pressure. All
// outputs are registered and change only on the clk edge after pix_ce=1,
// except line_start/frame_start (single-clk pulses) and the delayed syncs.
interface vga_raster_gen_if import vga_raster_gen_pkg::*; ();

  logic                pix_ce;
  logic [HCNT_W-1:0]   gr_x;
  logic [VCNT_W-1:0]   gr_y;
  logic                enable;
  logic                line_start;
  logic                frame_start;
  logic                hsync;
  logic                vsync;
  raster_dbg_t         dbg;

  modport master (
    input  pix_ce,
    output gr_x, gr_y, enable, line_start, frame_start, hsync, vsync, dbg
  );

  modport slave (
    output pix_ce,
    input  gr_x, gr_y, enable, line_start, frame_start, hsync, vsync, dbg
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for a single sync line. It shifts every clk
// so downstream pipeline latency is matched in clk cycles, not pixels.
// DEPTH=0 is a straight wire.
module sync_delay_line #(
  parameter int unsigned DEPTH   = 1,
  parameter bit          RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = clk ^ reset;
    assign dout       = din;
  end else begin : g_reg
    logic [DEPTH-1:0] stages;

    // Shift one stage per clk; reset parks every stage at the idle level.
    always_ff @(posedge clk) begin
      if (reset) begin
        stages <= {DEPTH{RST_LVL}};
      end else begin
        stages[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stages[i] <= stages[i-1];
        end
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster timing generator. hcnt/vcnt hold the next pixel to emit; on
// every pix_ce the registered outputs take that pixel and the counters step
// on. A small FSM tracks the horizontal phase of hcnt so hsync is a state
// decode rather than a range compare. Raw syncs are registered alongside
// gr_x and then delayed by SYNC_DLY clk to line up with draw-block output.
module vga_raster_gen
  import vga_raster_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_raster_gen_if.master vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Full-width boundary constants so every compare is on counter width.
  localparam logic [HCNT_W-1:0] H_ACT_W     = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] H_ACT_LAST  = HCNT_W'(H_ACTIVE - 1);
  localparam logic [HCNT_W-1:0] H_FP_LAST   = HCNT_W'(H_ACTIVE + H_FP - 1);
  localparam logic [HCNT_W-1:0] H_SYNC_LAST = HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HCNT_W-1:0] H_LAST      = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_ACT_W     = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] V_SYNC_FST  = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] V_SYNC_LAST = VCNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VCNT_W-1:0] V_LAST      = VCNT_W'(V_TOTAL - 1);

  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  h_phase_e          h_phase;
  logic              h_wrap;
  logic              v_wrap;
  logic              vs_active;

  logic [HCNT_W-1:0] gr_x_q;
  logic [VCNT_W-1:0] gr_y_q;
  logic              enable_q;
  logic              line_start_q;
  logic              frame_start_q;
  logic              raw_hsync;
  logic              raw_vsync;

  assign h_wrap    = (hcnt == H_LAST);
  assign v_wrap    = (vcnt == V_LAST);
  assign vs_active = (vcnt >= V_SYNC_FST) && (vcnt <= V_SYNC_LAST);

  // Raster counters: column steps per pixel, line steps on column wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (vif.pix_ce) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? '0 : vcnt + VCNT_W'(1);
      end else begin
        hcnt <= hcnt + HCNT_W'(1);
      end
    end
  end

  // Horizontal phase FSM for hcnt: leaves each phase on its last column.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_phase <= PH_ACTIVE;
    end else if (vif.pix_ce) begin
      case (h_phase)
        PH_ACTIVE: if (hcnt == H_ACT_LAST)  h_phase <= PH_FRONT;
        PH_FRONT:  if (hcnt == H_FP_LAST)   h_phase <= PH_SYNC;
        PH_SYNC:   if (hcnt == H_SYNC_LAST) h_phase <= PH_BACK;
        PH_BACK:   if (h_wrap)              h_phase <= PH_ACTIVE;
        default:                            h_phase <= PH_ACTIVE;
      endcase
    end
  end

  // Output registers: load the pending pixel on pix_ce; pulses drop otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      gr_x_q        <= '0;
      gr_y_q        <= '0;
      enable_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      raw_hsync     <= ~SYNC_POL;
      raw_vsync     <= ~SYNC_POL;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (vif.pix_ce) begin
        gr_x_q        <= hcnt;
        gr_y_q        <= vcnt;
        enable_q      <= (hcnt < H_ACT_W) && (vcnt < V_ACT_W);
        line_start_q  <= (hcnt == '0);
        frame_start_q <= (hcnt == '0) && (vcnt == '0);
        raw_hsync     <= sync_level(h_phase == PH_SYNC, SYNC_POL);
        raw_vsync     <= sync_level(vs_active, SYNC_POL);
      end
    end
  end

  sync_delay_line #(
    .DEPTH   (SYNC_DLY),
    .RST_LVL (~SYNC_POL)
  ) u_hsync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (raw_hsync),
    .dout  (vif.hsync)
  );

  sync_delay_line #(
    .DEPTH   (SYNC_DLY),
    .RST_LVL (~SYNC_POL)
  ) u_vsync_dly (
    .clk   (clk),
    .reset (reset),
    .din   (raw_vsync),
    .dout  (vif.vsync)
  );

  assign vif.gr_x        = gr_x_q;
  assign vif.gr_y        = gr_y_q;
  assign vif.enable      = enable_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.dbg         = {h_phase, hcnt, vcnt};

endmodule

// File: tb/tb_vga_raster_gen.sv
// Bench for vga_raster_gen. Two instances share clk/reset/pix_ce: one with
// default 800x600 timing and no sync delay, one with a tiny raster, active-low
// syncs and a 2-clk sync delay so whole frames fit in a short run.
module tb_vga_raster_gen;
  import vga_raster_gen_pkg::*;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, dly;
    bit pol;
  } tim_t;

  typedef struct {
    longint   n;
    int       x, y;
    bit       en, ls, fs;
    bit [3:0] hh, vh;
  } mdl_t;

  typedef struct {
    bit ce, rst;
    int x, y;
    bit en, ls, fs;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  tim_t tim[2];
  mdl_t mdl[2];
  vec_t vecs[10];

  vga_raster_gen_if if_a ();
  vga_raster_gen_if if_b ();
  assign if_a.pix_ce = pix_ce;
  assign if_b.pix_ce = pix_ce;

  vga_raster_gen #(.SYNC_DLY(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .vif   (if_a)
  );

  vga_raster_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .SYNC_POL(1'b0), .SYNC_DLY(2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .vif   (if_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pixel n after reset is raster position n mod (HT*VT), row-major.
  task automatic model_clk(input int i, input bit ce, input bit rst);
    int  ht, vt, p, hs0, vs0;
    bit  hact, vact;
    ht  = tim[i].ha + tim[i].hfp + tim[i].hs + tim[i].hbp;
    vt  = tim[i].va + tim[i].vfp + tim[i].vs + tim[i].vbp;
    hs0 = tim[i].ha + tim[i].hfp;
    vs0 = tim[i].va + tim[i].vfp;
    if (rst) begin
      mdl[i].n = 0; mdl[i].x = 0; mdl[i].y = 0;
      mdl[i].en = 0; mdl[i].ls = 0; mdl[i].fs = 0;
      mdl[i].hh = '0; mdl[i].vh = '0;
    end else begin
      if (ce) begin
        p = int'(mdl[i].n % longint'(ht * vt));
        mdl[i].x  = p % ht;
        mdl[i].y  = p / ht;
        mdl[i].en = (mdl[i].x < tim[i].ha) && (mdl[i].y < tim[i].va);
        mdl[i].ls = (mdl[i].x == 0);
        mdl[i].fs = (p == 0);
        mdl[i].n++;
      end else begin
        mdl[i].ls = 0;
        mdl[i].fs = 0;
      end
      hact = (mdl[i].x >= hs0) && (mdl[i].x < hs0 + tim[i].hs);
      vact = (mdl[i].y >= vs0) && (mdl[i].y < vs0 + tim[i].vs);
      mdl[i].hh = {mdl[i].hh[2:0], hact};
      mdl[i].vh = {mdl[i].vh[2:0], vact};
    end
  endtask

  function automatic logic [25:0] exp_vec(input int i);
    logic hs_e, vs_e;
    hs_e = mdl[i].hh[tim[i].dly] ? tim[i].pol : ~tim[i].pol;
    vs_e = mdl[i].vh[tim[i].dly] ? tim[i].pol : ~tim[i].pol;
    return {11'(mdl[i].x), 10'(mdl[i].y), mdl[i].en, mdl[i].ls, mdl[i].fs, hs_e, vs_e};
  endfunction

  function automatic logic [25:0] act_vec(input int i);
    if (i == 0)
      return {if_a.gr_x, if_a.gr_y, if_a.enable, if_a.line_start, if_a.frame_start,
              if_a.hsync, if_a.vsync};
    return {if_b.gr_x, if_b.gr_y, if_b.enable, if_b.line_start, if_b.frame_start,
            if_b.hsync, if_b.vsync};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_model(input int i);
    logic [25:0] a, e;
    a = act_vec(i);
    e = exp_vec(i);
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL model_%0s cyc=%0d got x=%0d y=%0d en,ls,fs,hs,vs=%b expected x=%0d y=%0d en,ls,fs,hs,vs=%b",
               (i == 0) ? "a" : "b", cyc, a[25:15], a[14:5], a[4:0], e[25:15], e[14:5], e[4:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit ce, input bit rst);
    @(negedge clk);
    pix_ce = ce;
    reset  = rst;
    @(posedge clk);
    model_clk(0, ce, rst);
    model_clk(1, ce, rst);
    #1;
    cyc++;
    chk_model(0);
    chk_model(1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a_last_en_x, a_hs_cnt, a_hs_first, a_hs_last, a_ls_y1;
    int b_prev_y, b_bad_en, b_x19_cyc, b_hs_cyc, prev_x;
    bit b_wrap, found;
    int fs_q[$];

    tim[0] = '{800, 40, 128, 88, 600, 1, 4, 23, 0, 1'b1};
    tim[1] = '{16, 3, 5, 4, 10, 2, 3, 2, 2, 1'b0};
    for (int i = 0; i < 2; i++) model_clk(i, 1'b0, 1'b1);

    vecs[0] = '{1, 0, 0, 0, 1, 1, 1};
    vecs[1] = '{0, 0, 0, 0, 1, 0, 0};
    vecs[2] = '{1, 0, 1, 0, 1, 0, 0};
    vecs[3] = '{0, 0, 1, 0, 1, 0, 0};
    vecs[4] = '{1, 0, 2, 0, 1, 0, 0};
    vecs[5] = '{1, 0, 3, 0, 1, 0, 0};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{1, 0, 0, 0, 1, 1, 1};
    vecs[9] = '{1, 0, 1, 0, 1, 0, 0};

    // Reset state
    repeat (3) step(1'b0, 1'b1);
    chk("rst_a_x", if_a.gr_x, 0);
    chk("rst_a_en", if_a.enable, 0);
    chk("rst_a_hsync_idle", if_a.hsync, 0);
    chk("rst_b_hsync_idle", if_b.hsync, 1);
    chk("rst_b_vsync_idle", if_b.vsync, 1);

    // Table-driven start-up / hold / reset-override vectors
    for (int k = 0; k < 10; k++) begin
      step(vecs[k].ce, vecs[k].rst);
      chk($sformatf("vec%0d_b", k),
          {if_b.gr_x, if_b.gr_y, if_b.enable, if_b.line_start, if_b.frame_start},
          {11'(vecs[k].x), 10'(vecs[k].y), vecs[k].en, vecs[k].ls, vecs[k].fs});
      chk($sformatf("vec%0d_a", k),
          {if_a.gr_x, if_a.gr_y, if_a.enable, if_a.line_start, if_a.frame_start},
          {11'(vecs[k].x), 10'(vecs[k].y), vecs[k].en, vecs[k].ls, vecs[k].fs});
    end

    // Constant pix_ce: line boundaries on A, frames and sync delay on B
    step(1'b0, 1'b1);
    a_last_en_x = -1; a_hs_cnt = 0; a_hs_first = -1; a_hs_last = -1; a_ls_y1 = 0;
    b_prev_y = 0; b_bad_en = 0; b_x19_cyc = -1; b_hs_cyc = -1; b_wrap = 0;
    for (int k = 0; k < 2130; k++) begin
      step(1'b1, 1'b0);
      if (if_a.gr_y == 0) begin
        if (if_a.enable) a_last_en_x = int'(if_a.gr_x);
        if (if_a.hsync) begin
          a_hs_cnt++;
          if (a_hs_first < 0) a_hs_first = int'(if_a.gr_x);
          a_hs_last = int'(if_a.gr_x);
        end
      end
      if (if_a.gr_y == 1 && if_a.gr_x == 0 && if_a.line_start) a_ls_y1++;
      if (if_b.frame_start) fs_q.push_back(cyc);
      if (b_prev_y == 16 && if_b.gr_y == 0) b_wrap = 1;
      b_prev_y = int'(if_b.gr_y);
      if (if_b.gr_y >= 10 && if_b.enable) b_bad_en++;
      if (b_x19_cyc < 0 && if_b.gr_x == 19) b_x19_cyc = cyc;
      if (b_x19_cyc >= 0 && b_hs_cyc < 0 && if_b.hsync == 1'b0) b_hs_cyc = cyc;
    end
    chk("a_last_enable_x", a_last_en_x, 799);
    chk("a_hsync_width", a_hs_cnt, 128);
    chk("a_hsync_first_x", a_hs_first, 840);
    chk("a_hsync_last_x", a_hs_last, 967);
    chk("a_line_start_y1", a_ls_y1, 1);
    chk("b_frame_pulses", fs_q.size() >= 3, 1);
    if (fs_q.size() >= 3) begin
      chk("b_frame_len0", fs_q[1] - fs_q[0], 476);
      chk("b_frame_len1", fs_q[2] - fs_q[1], 476);
    end
    chk("b_y_wrap", b_wrap, 1);
    chk("b_no_enable_blank", b_bad_en, 0);
    chk("b_hsync_delay", b_hs_cyc - b_x19_cyc, 2);

    // pix_ce toggling: one pixel every second clk, pulses never stretched
    step(1'b0, 1'b1);
    prev_x = 27;
    for (int k = 0; k < 80; k++) begin
      step(k[0] == 1'b0, 1'b0);
      if (k[0] == 1'b0) begin
        chk("toggle_x_step", if_b.gr_x, (prev_x + 1) % 28);
        prev_x = int'(if_b.gr_x);
      end else begin
        chk("toggle_pulse_low", {if_b.line_start, if_b.frame_start}, 0);
      end
    end

    // Mid-frame reset with pix_ce high
    step(1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      step(1'b1, 1'b0);
      if (if_b.gr_x == 5 && if_b.gr_y == 3) found = 1;
    end
    chk("reach_mid_frame", found, 1);
    step(1'b1, 1'b1);
    chk("midrst_b_outs",
        {if_b.gr_x, if_b.gr_y, if_b.enable, if_b.line_start, if_b.frame_start}, 0);
    chk("midrst_b_syncs", {if_b.hsync, if_b.vsync}, 2'b11);
    chk("midrst_a_outs", {if_a.gr_x, if_a.enable, if_a.hsync}, 0);
    step(1'b1, 1'b0);
    chk("midrst_b_first",
        {if_b.gr_x, if_b.gr_y, if_b.enable, if_b.frame_start}, {21'd0, 2'b11});

    // Randomized pix_ce with occasional resets, checked by the model
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 599) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_raster_gen.md
VGA_RASTER_GEN -- requirements
Module: vga_raster_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 Parameter H_FP, default 40: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 128: hsync width, in pixels.
REQ-004 Parameter H_BP, default 88: horizontal back porch; H_TOTAL = 1056.
REQ-005 Parameter V_ACTIVE, default 600: visible lines per frame.
REQ-006 Parameter V_FP, default 1: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 4: vsync width, in lines.
REQ-008 Parameter V_BP, default 23: vertical back porch; V_TOTAL = 628.
REQ-009 Parameter SYNC_POL, default 1: active level of hsync/vsync.
REQ-010 Parameter SYNC_DLY, default 1, range 0..3: extra clk cycles of delay on hsync/vsync, matching downstream draw-block latency.
REQ-011 clk  in  1  sole clock, rising edge.
REQ-012 reset  in  1  synchronous, active-high reset.
REQ-013 pix_ce  in  1  pixel clock enable; the raster advances only on cycles with pix_ce=1.
REQ-014 gr_x  out  11  current pixel column, 0..H_TOTAL-1.
REQ-015 gr_y  out  10  current pixel line, 0..V_TOTAL-1.
REQ-016 enable  out  1  1 when (gr_x,gr_y) is inside the visible area.
REQ-017 line_start  out  1  1 on the output cycle where gr_x=0.
REQ-018 frame_start  out  1  1 on the output cycle where gr_x=0 and gr_y=0.
REQ-019 hsync  out  1  horizontal sync, level SYNC_POL while active.
REQ-020 vsync  out  1  vertical sync, level SYNC_POL while active.

Function
REQ-021 Internal counters hcnt (11 b) and vcnt (10 b) hold the next pixel to emit.
REQ-022 On clk with pix_ce=1, hcnt increments, wrapping H_TOTAL-1 -> 0.
REQ-023 On that hcnt wrap, vcnt increments, wrapping V_TOTAL-1 -> 0; the frame wrap occurs only on the cycle where both counters wrap.
REQ-024 On clk with pix_ce=1, registered outputs load: gr_x<=hcnt, gr_y<=vcnt, enable<=(hcnt<H_ACTIVE && vcnt<V_ACTIVE), line_start<=(hcnt==0), frame_start<=(hcnt==0 && vcnt==0); output latency is 1 clk after pix_ce.
REQ-025 On clk with pix_ce=0, counters, gr_x, gr_y, enable and syncs hold; line_start and frame_start SHALL be 0 (pulses last exactly one clk).
REQ-026 Horizontal phase is a 4-state FSM: ACTIVE (hcnt<H_ACTIVE) -> FRONT -> SYNC -> BACK -> ACTIVE, transitions on hcnt boundaries H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and 0.
REQ-027 Raw hsync is active when the emitted pixel's phase is SYNC, i.e. gr_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [840,967] by default.
REQ-028 Raw vsync is active when gr_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [601,604] by default, for every pixel of those lines.
REQ-029 hsync/vsync outputs are the raw syncs passed through a SYNC_DLY-stage clk shift register, shifting every clk regardless of pix_ce; SYNC_DLY=0 gives the raw sync aligned with gr_x.
REQ-030 All arithmetic is unsigned, and comparisons use full counter width without truncation.

Reset
REQ-031 While reset=1 at a clk edge: hcnt=0, vcnt=0, FSM=ACTIVE, gr_x=0, gr_y=0, enable=0, line_start=0, frame_start=0, and all sync delay stages and outputs are at the inactive level (!SYNC_POL).
REQ-032 Reset overrides pix_ce, and a reset mid-frame restarts at pixel (0,0) with no partial-line output.
REQ-033 The first pix_ce=1 cycle after reset emits (0,0) with enable=1 and frame_start=1.

Structure
REQ-034 The default timing values, the derived H_TOTAL/V_TOTAL, and the horizontal phase state encoding live in a shared display timing package used by all draw blocks.
REQ-035 The sync delay line is one sub-module, sync_delay_line, parameterized by depth and reset level.

Verification
REQ-036 Reset, then pix_ce=1 constant -> first output cycle gr_x=0, gr_y=0, enable=1, frame_start=1; gr_x=799 is the last enable=1 pixel of the line.
REQ-037 Run one full frame -> 1056*628 = 663168 pix_ce cycles between frame_start pulses; gr_y wraps 627->0; enable=0 for all gr_y>=600.
REQ-038 With SYNC_DLY=0 -> hsync=1 exactly for gr_x 840..967 (128 pixels); vsync=1 exactly for gr_y 601..604.
REQ-039 pix_ce toggling 1,0,1,0 -> gr_x advances every second clk, and line_start/frame_start are single-clk pulses, never held during pix_ce=0 cycles.
REQ-040 Assert reset at gr_x=500, gr_y=300 for 1 clk -> all outputs 0 and syncs inactive, then the next pix_ce cycle emits (0,0) with frame_start=1.
REQ-041 With SYNC_DLY=2 and pix_ce=1 -> hsync rises 2 clk after the cycle gr_x=840 is emitted.
